// File: rtl/sprite_move_scheduler.sv
// sprite_move_scheduler
//   Shares one position_update_function among the sprites (pacman=0, blinky=1,
//   pinky=2, inky=3, clyde=4). A game tick runs one round. Each sprite is issued
//   in index order, the updater latency is waited out, and the result is captured.
//   After rst or soft_restart an init sweep loads the reset positions through the
//   updater, with upd_rst held high. At the end of a round the ghost positions are
//   compared against pacman.
// Ports
//   clk, rst         clock; synchronous active-high reset
//   tick             1-cycle pulse requesting a movement round
//   soft_restart     1-cycle pulse requesting an init sweep
//   dir_in           per-sprite move direction, 4 bits each, sprite i at [4i+3:4i]
//   upd_curr_x/y     current position driven to the updater
//   upd_dir          direction driven to the updater (0 during init)
//   upd_sprite       sprite index driven to the updater
//   upd_rst          updater reset; high only during the init sweep
//   upd_new_x/y      updater result, valid UPD_LATENCY cycles after stable inputs
//   pos_x/pos_y      packed sprite positions
//   busy             high whenever the scheduler is not idle
//   round_done       1-cycle pulse once every capture of a round has landed
//   collide          bit g-1 set when ghost g sits on pacman; valid with round_done
//   overrun          sticky; set when a tick arrives while one is already pending
module sprite_move_scheduler #(
   parameter int UPD_LATENCY = 2,
   parameter int NUM_SPRITES = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tick,
   input  logic                      soft_restart,
   input  logic [4*NUM_SPRITES-1:0]  dir_in,
   output logic [10:0]               upd_curr_x,
   output logic [9:0]                upd_curr_y,
   output logic [3:0]                upd_dir,
   output logic [2:0]                upd_sprite,
   output logic                      upd_rst,
   input  logic [10:0]               upd_new_x,
   input  logic [9:0]                upd_new_y,
   output logic [11*NUM_SPRITES-1:0] pos_x,
   output logic [10*NUM_SPRITES-1:0] pos_y,
   output logic                      busy,
   output logic                      round_done,
   output logic [NUM_SPRITES-2:0]    collide,
   output logic                      overrun
);

   localparam int         CNT_W    = (UPD_LATENCY > 1) ? $clog2(UPD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UPD_LATENCY - 1);
   localparam logic [2:0] LAST_IDX = 3'(NUM_SPRITES - 1);

   typedef enum logic [2:0] {
      S_INIT_ISSUE, S_INIT_WAIT, S_IDLE, S_ISSUE, S_WAIT, S_DONE
   } state_t;

   state_t                  state_reg, state_next;
   logic [2:0]              idx_reg, idx_next;
   logic [CNT_W-1:0]        wait_cnt_reg, wait_cnt_next;
   logic                    tick_pending_reg, tick_pending_next;
   logic                    restart_pending_reg, restart_pending_next;
   logic                    overrun_reg, overrun_next;
   logic [NUM_SPRITES-2:0]  collide_reg, collide_next;
   logic                    snap_en;
   logic                    cap_en;
   logic                    init_mode;

   logic [10:0]             pos_x_arr [NUM_SPRITES];
   logic [9:0]              pos_y_arr [NUM_SPRITES];
   logic [3:0]              dir_arr   [NUM_SPRITES];
   logic [NUM_SPRITES-2:0]  match;

   // Per-sprite storage: position capture, direction snapshot, output packing.
   generate
      for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
         logic [10:0] x_reg;
         logic [9:0]  y_reg;
         logic [3:0]  dir_snap_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               x_reg        <= '0;
               y_reg        <= '0;
               dir_snap_reg <= '0;
            end else begin
               if (cap_en && (idx_reg == 3'(gi))) begin
                  x_reg <= upd_new_x;
                  y_reg <= upd_new_y;
               end
               if (snap_en) begin
                  dir_snap_reg <= dir_in[4*gi +: 4];
               end
            end
         end

         assign pos_x_arr[gi]     = x_reg;
         assign pos_y_arr[gi]     = y_reg;
         assign dir_arr[gi]       = dir_snap_reg;
         assign pos_x[11*gi +: 11] = x_reg;
         assign pos_y[10*gi +: 10] = y_reg;
      end

      for (genvar gi = 1; gi < NUM_SPRITES; gi++) begin : g_match
         assign match[gi-1] = (pos_x_arr[gi] == pos_x_arr[0]) &&
                              (pos_y_arr[gi] == pos_y_arr[0]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= S_INIT_ISSUE;
         idx_reg             <= '0;
         wait_cnt_reg        <= '0;
         tick_pending_reg    <= 1'b0;
         restart_pending_reg <= 1'b0;
         overrun_reg         <= 1'b0;
         collide_reg         <= '0;
      end else begin
         state_reg           <= state_next;
         idx_reg             <= idx_next;
         wait_cnt_reg        <= wait_cnt_next;
         tick_pending_reg    <= tick_pending_next;
         restart_pending_reg <= restart_pending_next;
         overrun_reg         <= overrun_next;
         collide_reg         <= collide_next;
      end
   end

   always_comb begin
      state_next           = state_reg;
      idx_next             = idx_reg;
      wait_cnt_next        = wait_cnt_reg;
      tick_pending_next    = tick_pending_reg;
      restart_pending_next = restart_pending_reg;
      overrun_next         = overrun_reg;
      collide_next         = collide_reg;
      snap_en              = 1'b0;
      cap_en               = 1'b0;

      // Requests arriving while busy are queued; one tick deep, extra ones are dropped.
      if (state_reg != S_IDLE) begin
         if (tick) begin
            if (tick_pending_reg) overrun_next = 1'b1;
            else                  tick_pending_next = 1'b1;
         end
         if (soft_restart) restart_pending_next = 1'b1;
      end

      case (state_reg)
         S_INIT_ISSUE, S_ISSUE: begin
            wait_cnt_next = '0;
            state_next    = (state_reg == S_ISSUE) ? S_WAIT : S_INIT_WAIT;
         end
         S_INIT_WAIT, S_WAIT: begin
            if (wait_cnt_reg == LAST_CNT) begin
               cap_en = 1'b1;
               if (idx_reg == LAST_IDX) begin
                  idx_next   = '0;
                  state_next = (state_reg == S_WAIT) ? S_DONE : S_IDLE;
               end else begin
                  idx_next   = idx_reg + 3'd1;
                  state_next = (state_reg == S_WAIT) ? S_ISSUE : S_INIT_ISSUE;
               end
            end else begin
               wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            end
         end
         S_IDLE: begin
            // Restart wins over tick; a coincident tick is kept for after the sweep.
            if (soft_restart || restart_pending_reg) begin
               restart_pending_next = 1'b0;
               idx_next             = '0;
               state_next           = S_INIT_ISSUE;
               if (tick) begin
                  if (tick_pending_reg) overrun_next = 1'b1;
                  else                  tick_pending_next = 1'b1;
               end
            end else if (tick || tick_pending_reg) begin
               tick_pending_next = 1'b0;
               snap_en           = 1'b1;
               idx_next          = '0;
               state_next        = S_ISSUE;
            end
         end
         S_DONE: begin
            collide_next = match;
            state_next   = S_IDLE;
         end
         default: state_next = S_INIT_ISSUE;
      endcase
   end

   assign init_mode  = (state_reg == S_INIT_ISSUE) || (state_reg == S_INIT_WAIT);
   assign upd_curr_x = pos_x_arr[idx_reg];
   assign upd_curr_y = pos_y_arr[idx_reg];
   assign upd_dir    = init_mode ? 4'd0 : dir_arr[idx_reg];
   assign upd_sprite = idx_reg;
   assign upd_rst    = init_mode;
   assign busy       = (state_reg != S_IDLE);
   assign round_done = (state_reg == S_DONE);
   // The last capture lands on the edge into DONE, so compare live during DONE.
   assign collide    = (state_reg == S_DONE) ? match : collide_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: a two-stage updater model feeds the DUT, a
// round-level reference model predicts outputs each cycle, and directed tests
// pin the model with hand-computed literals.
module tb_sprite_move_scheduler;

   localparam int LAT   = 2;
   localparam int SLOT  = LAT + 1;
   localparam int SWEEP = 5 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        soft_restart = 1'b0;
   logic [19:0] dir_in = '0;
   logic [10:0] upd_curr_x;
   logic [9:0]  upd_curr_y;
   logic [3:0]  upd_dir;
   logic [2:0]  upd_sprite;
   logic        upd_rst;
   logic [10:0] upd_new_x;
   logic [9:0]  upd_new_y;
   logic [54:0] pos_x;
   logic [49:0] pos_y;
   logic        busy;
   logic        round_done;
   logic [3:0]  collide;
   logic        overrun;

   int total = 0;
   int bad   = 0;
   int rd_cnt = 0;

   always #5 clk = ~clk;

   sprite_move_scheduler #(.UPD_LATENCY(LAT), .NUM_SPRITES(5)) dut (
      .clk(clk), .rst(rst), .tick(tick), .soft_restart(soft_restart), .dir_in(dir_in),
      .upd_curr_x(upd_curr_x), .upd_curr_y(upd_curr_y), .upd_dir(upd_dir),
      .upd_sprite(upd_sprite), .upd_rst(upd_rst),
      .upd_new_x(upd_new_x), .upd_new_y(upd_new_y),
      .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .round_done(round_done),
      .collide(collide), .overrun(overrun)
   );

   // ---------------- updater model ----------------
   // Reset positions on upd_rst; one-hot directions move 16 units; anything else holds.
   logic        force_en = 1'b0;
   logic [10:0] force_x  = '0;
   logic [9:0]  force_y  = '0;

   function automatic logic [20:0] upd_fn(input logic [10:0] x, input logic [9:0] y,
                                          input logic [3:0] d, input logic [2:0] s,
                                          input logic r);
      logic [20:0] res;
      if (r) begin
         case (s)
            3'd0: res = {11'd967, 10'd66};
            3'd1: res = {11'd663, 10'd434};
            3'd2: res = {11'd615, 10'd258};
            3'd3: res = {11'd503, 10'd66};
            3'd4: res = {11'd615, 10'd370};
            default: res = '0;
         endcase
      end else if (force_en && s == 3'd1) begin
         res = {force_x, force_y};
      end else begin
         case (d)
            4'd1: res = {x + 11'd16, y};
            4'd2: res = {x - 11'd16, y};
            4'd4: res = {x, y - 10'd16};
            4'd8: res = {x, y + 10'd16};
            default: res = {x, y};
         endcase
      end
      return res;
   endfunction

   logic [20:0] stage1 = '0;
   logic [20:0] stage2 = '0;
   always @(posedge clk) begin
      stage1 <= upd_fn(upd_curr_x, upd_curr_y, upd_dir, upd_sprite, upd_rst);
      stage2 <= stage1;
   end
   assign upd_new_x = stage2[20:10];
   assign upd_new_y = stage2[9:0];

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 init sweep, 2 round; el = cycles elapsed in the current activity.
   // A whole round's outcome is computed at its start; sprite k becomes visible
   // once its slot has ended (el >= SLOT*(k+1)).
   int          mode = 0;
   int          el = 0;
   bit          mvalid = 0;
   bit          m_tp = 0, m_rp = 0, m_ov = 0;
   logic [3:0]  m_col = '0;
   logic [10:0] cur_x [5];
   logic [9:0]  cur_y [5];
   logic [10:0] nw_x  [5];
   logic [9:0]  nw_y  [5];
   logic [3:0]  snap  [5];

   function automatic logic [3:0] hits();
      logic [3:0] h;
      for (int g = 1; g < 5; g++) h[g-1] = (nw_x[g] == nw_x[0]) && (nw_y[g] == nw_y[0]);
      return h;
   endfunction

   task automatic load_init();
      logic [20:0] r;
      for (int k = 0; k < 5; k++) begin
         r = upd_fn(cur_x[k], cur_y[k], 4'd0, 3'(k), 1'b1);
         nw_x[k] = r[20:10];
         nw_y[k] = r[9:0];
      end
   endtask

   task automatic queue_tick();
      if (m_tp) m_ov = 1;
      else      m_tp = 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         mvalid = 1; mode = 1; el = 0; m_tp = 0; m_rp = 0; m_ov = 0; m_col = '0;
         for (int k = 0; k < 5; k++) begin cur_x[k] = '0; cur_y[k] = '0; snap[k] = '0; end
         load_init();
      end else if (mvalid) begin
         if (mode == 0) begin
            if (soft_restart || m_rp) begin
               m_rp = 0;
               if (tick) queue_tick();
               mode = 1; el = 0;
               load_init();
            end else if (tick || m_tp) begin
               logic [20:0] r;
               m_tp = 0; mode = 2; el = 0;
               for (int k = 0; k < 5; k++) begin
                  snap[k] = dir_in[4*k +: 4];
                  r = upd_fn(cur_x[k], cur_y[k], snap[k], 3'(k), 1'b0);
                  nw_x[k] = r[20:10];
                  nw_y[k] = r[9:0];
               end
            end
         end else begin
            if (tick) queue_tick();
            if (soft_restart) m_rp = 1;
            if ((mode == 1 && el == SWEEP - 1) || (mode == 2 && el == SWEEP)) begin
               if (mode == 2) m_col = hits();
               for (int k = 0; k < 5; k++) begin cur_x[k] = nw_x[k]; cur_y[k] = nw_y[k]; end
               mode = 0; el = 0;
            end else begin
               el++;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (mvalid) begin
         logic [54:0] ex;
         logic [49:0] ey;
         bit          ed;
         int          slot;
         for (int k = 0; k < 5; k++) begin
            bit vis;
            vis = (mode != 0) && (el >= SLOT * (k + 1));
            ex[11*k +: 11] = vis ? nw_x[k] : cur_x[k];
            ey[10*k +: 10] = vis ? nw_y[k] : cur_y[k];
         end
         ed = (mode == 2) && (el == SWEEP);
         chk("busy", 64'(busy), 64'(mode != 0));
         chk("round_done", 64'(round_done), 64'(ed));
         chk("pos_x", 64'(pos_x), 64'(ex));
         chk("pos_y", 64'(pos_y), 64'(ey));
         chk("collide", 64'(collide), 64'(ed ? hits() : m_col));
         chk("overrun", 64'(overrun), 64'(m_ov));
         if (mode != 0 && !ed) begin
            slot = el / SLOT;
            chk("upd_rst", 64'(upd_rst), 64'(mode == 1));
            chk("upd_sprite", 64'(upd_sprite), 64'(slot));
            chk("upd_dir", 64'(upd_dir), 64'((mode == 1) ? 4'd0 : snap[slot]));
            chk("upd_curr_x", 64'(upd_curr_x), 64'(cur_x[slot]));
            chk("upd_curr_y", 64'(upd_curr_y), 64'(cur_y[slot]));
         end
      end
      if (round_done === 1'b1) rd_cnt++;
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic check_reset_positions(input string tag);
      chk({tag, "_p0"}, 64'({pos_x[10:0],  pos_y[9:0]}),   64'({11'd967, 10'd66}));
      chk({tag, "_p1"}, 64'({pos_x[21:11], pos_y[19:10]}), 64'({11'd663, 10'd434}));
      chk({tag, "_p2"}, 64'({pos_x[32:22], pos_y[29:20]}), 64'({11'd615, 10'd258}));
      chk({tag, "_p3"}, 64'({pos_x[43:33], pos_y[39:30]}), 64'({11'd503, 10'd66}));
      chk({tag, "_p4"}, 64'({pos_x[54:44], pos_y[49:40]}), 64'({11'd615, 10'd370}));
   endtask

   initial begin
      int n;
      int rd0;

      // Reset and init sweep
      step();
      rst = 1'b0;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk("init_busy_cycles", 64'(n), 64'd15);
      chk("init_no_round_done", 64'(rd_cnt), 64'd0);
      check_reset_positions("init");
      $display("txn init sweep: busy for %0d cycles", n);
      step();

      // Single round: pacman RIGHT, ghosts dir 0
      dir_in = 20'h00001;
      rd0 = rd_cnt;
      tick = 1'b1;
      @(posedge clk);
      #2 tick = 1'b0;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (round_done) break;
      end
      chk("round_latency", 64'(n), 64'd16);
      chk("round_pacman_x", 64'(pos_x[10:0]), 64'd983);
      chk("round_blinky_x", 64'(pos_x[21:11]), 64'd663);
      $display("txn round: round_done after %0d cycles, pacman x=%0d", n, pos_x[10:0]);
      step();
      step();

      // Three extra ticks during a round: one extra round, overrun set
      rd0 = rd_cnt;
      pulse_tick();
      repeat (3) step();
      pulse_tick();
      step();
      pulse_tick();
      step();
      pulse_tick();
      repeat (40) step();
      chk("overrun_rounds", 64'(rd_cnt - rd0), 64'd2);
      chk("overrun_flag", 64'(overrun), 64'd1);
      chk("overrun_pacman_x", 64'(pos_x[10:0]), 64'd1015);
      $display("txn overrun: %0d rounds, overrun=%0d", rd_cnt - rd0, overrun);

      // Collision: blinky forced onto pacman's result; inky given a non-one-hot dir
      force_en = 1'b1;
      force_x  = 11'd1031;
      force_y  = 10'd66;
      dir_in   = 20'h03001;
      tick = 1'b1;
      step();
      tick = 1'b0;
      n = 0;
      while (n < 40 && round_done !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      chk("collide_seen", 64'(round_done), 64'd1);
      chk("collide_value", 64'(collide), 64'b0001);
      chk("collide_inky_hold", 64'(pos_x[43:33]), 64'd503);
      $display("txn collide: collide=%b", collide);
      step();
      step();
      force_en = 1'b0;
      dir_in   = 20'h00001;

      // rst at cycle 7 of a round
      rd0 = rd_cnt;
      pulse_tick();
      repeat (6) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (20) step();
      chk("rst_mid_no_done", 64'(rd_cnt - rd0), 64'd0);
      chk("rst_mid_overrun", 64'(overrun), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      check_reset_positions("rst_mid");
      $display("txn rst mid-round: round_done pulses=%0d", rd_cnt - rd0);

      // soft_restart plus tick mid-round
      dir_in = 20'h80001;
      rd0 = rd_cnt;
      pulse_tick();
      repeat (4) step();
      tick = 1'b1;
      soft_restart = 1'b1;
      step();
      tick = 1'b0;
      soft_restart = 1'b0;
      repeat (60) step();
      chk("restart_rounds", 64'(rd_cnt - rd0), 64'd2);
      chk("restart_pacman_x", 64'(pos_x[10:0]), 64'd983);
      chk("restart_clyde_y", 64'(pos_y[49:40]), 64'd386);
      chk("restart_idle", 64'(busy), 64'd0);
      $display("txn soft_restart: %0d rounds, pacman x=%0d clyde y=%0d",
               rd_cnt - rd0, pos_x[10:0], pos_y[49:40]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
